// File: rtl/qspi_pkg.sv
// Shared types and helpers for the multi-lane SPI slave.
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_1 = 2'b00,
    LANE_2 = 2'b01,
    LANE_4 = 2'b10
  } lane_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } qspi_state_t;

  localparam int unsigned StatusUnderrun = 0;
  localparam int unsigned StatusOverrun  = 1;
  localparam int unsigned StatusAbort    = 2;

  // Reserved encoding 2'b11 behaves as quad.
  function automatic lane_mode_t lanes_of(input logic [1:0] mode);
    lane_mode_t lm;
    case (mode)
      2'b00:   lm = LANE_1;
      2'b01:   lm = LANE_2;
      default: lm = LANE_4;
    endcase
    return lm;
  endfunction

endpackage

// File: rtl/qspi_slave_ctrl_if.sv
// Pad-side and host-side signal bundle of qspi_slave_ctrl.
interface qspi_slave_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cs_n;
  logic [1:0]        mode;
  logic [3:0]        mosi;
  logic [3:0]        miso;
  logic [3:0]        miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [2:0]        status;
  logic              status_clr;

  modport slave (
    input  cs_n, mode, mosi, tx_data, tx_valid, rx_ready, status_clr,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, status
  );

  modport master (
    output cs_n, mode, mosi, tx_data, tx_valid, rx_ready, status_clr,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, status
  );
endinterface

// File: rtl/qspi_sync_fifo.sv
// Single-clock FIFO, async active-high reset; push is accepted when full if a pop happens too.
module qspi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/qspi_slave_ctrl.sv
// 1/2/4-lane SPI slave with TX/RX FIFOs, all in the sclk domain.
// Define QSPI_SLV_MSB_FIRST_EN for MSB-first words (left shift); default is LSB-first.
module qspi_slave_ctrl
  import qspi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              sclk,
  input logic              reset,
  qspi_slave_ctrl_if.slave bus
);
  localparam int unsigned BeatW = $clog2(DATA_W);

  qspi_state_t       state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d, last_beat;
  lane_mode_t        lane_q, lane_d, cur_lane;
  logic [DATA_W-1:0] shreg_q, shreg_d, src;
  logic [3:0]        miso_q, miso_d, oe_q, oe_d, lane_mask;
  logic [2:0]        lane_n;
  logic [2:0]        status_q, status_d, status_set;
  logic              frame_start, tx_pop, rx_push, host_pop;
  logic [DATA_W-1:0] tx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;

  qspi_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .sclk   (sclk),
    .reset  (reset),
    .push_i (bus.tx_valid & ~tx_full),
    .wdata_i(bus.tx_data),
    .pop_i  (tx_pop),
    .rdata_o(tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  qspi_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .sclk   (sclk),
    .reset  (reset),
    .push_i (rx_push),
    .wdata_i(shreg_d),
    .pop_i  (bus.rx_ready),
    .rdata_o(bus.rx_data),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  assign host_pop    = bus.rx_ready & ~rx_empty;
  // beat_q is held at 0 in IDLE, so 0 marks every frame boundary.
  assign frame_start = (beat_q == '0) && !bus.cs_n;
  assign cur_lane    = frame_start ? lanes_of(bus.mode) : lane_q;

  always_comb begin
    lane_n    = 3'd4;
    lane_mask = 4'b1111;
    last_beat = BeatW'(DATA_W / 4 - 1);
    case (cur_lane)
      LANE_1: begin
        lane_n    = 3'd1;
        lane_mask = 4'b0001;
        last_beat = BeatW'(DATA_W - 1);
      end
      LANE_2: begin
        lane_n    = 3'd2;
        lane_mask = 4'b0011;
        last_beat = BeatW'(DATA_W / 2 - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lane_d     = lane_q;
    shreg_d    = shreg_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    status_set = '0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    src        = shreg_q;

    if (frame_start) begin
      lane_d                     = cur_lane;
      tx_pop                     = ~tx_empty;
      src                        = tx_empty ? '0 : tx_head;
      status_set[StatusUnderrun] = tx_empty;
    end

    if (!bus.cs_n) begin
      state_d = SHIFT;
      oe_d    = lane_mask;
`ifdef QSPI_SLV_MSB_FIRST_EN
      miso_d  = src[DATA_W-1 -: 4] >> (3'd4 - lane_n);
      shreg_d = (src << lane_n) | DATA_W'(bus.mosi & lane_mask);
`else
      miso_d  = src[3:0] & lane_mask;
      shreg_d = (src >> lane_n) | (DATA_W'(bus.mosi & lane_mask) << (DATA_W - lane_n));
`endif
      if (beat_q == last_beat) begin
        beat_d                    = '0;
        rx_push                   = 1'b1;
        status_set[StatusOverrun] = rx_full & ~host_pop;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end else begin
      state_d                 = IDLE;
      beat_d                  = '0;
      miso_d                  = '0;
      oe_d                    = '0;
      status_set[StatusAbort] = (state_q == SHIFT) && (beat_q != '0);
    end

    status_d = (bus.status_clr ? 3'b000 : status_q) | status_set;
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lane_q   <= LANE_1;
      shreg_q  <= '0;
      miso_q   <= '0;
      oe_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lane_q   <= lane_d;
      shreg_q  <= shreg_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      status_q <= status_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = oe_q;
  assign bus.status   = status_q;
  assign bus.tx_ready = ~tx_full;
  assign bus.rx_valid = ~rx_empty;

endmodule

// File: tb/tb_qspi_slave_ctrl.sv
// Directed bench for qspi_slave_ctrl; expectations follow QSPI_SLV_MSB_FIRST_EN when defined.
module tb_qspi_slave_ctrl;
  localparam int unsigned DATA_W = 8;
`ifdef QSPI_SLV_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  logic sclk = 1'b0;
  logic reset;
  always #5 sclk = ~sclk;

  qspi_slave_ctrl_if #(.DATA_W(DATA_W)) bus ();

  qspi_slave_ctrl #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(4)
  ) dut (
    .sclk (sclk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic push_tx(input logic [7:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check(tag, 32'(bus.rx_data), 32'(exp));
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
  endtask

  task automatic beat(input logic [3:0] m);
    bus.cs_n = 1'b0;
    bus.mosi = m;
    step();
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    bus.mosi = 4'h0;
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, 32'(bus.miso), 32'h0);
    check({tag, "_oe"}, 32'(bus.miso_oe), 32'h0);
    check({tag, "_status"}, 32'(bus.status), 32'h0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
  endtask

  // Quad word built from two nibble beats in the active bit order.
  function automatic logic [7:0] quad_word(input logic [3:0] b0, input logic [3:0] b1);
    return MsbFirst ? {b0, b1} : {b1, b0};
  endfunction

  logic [3:0] exp_miso_dual [8];
  logic [3:0] mosi_dual     [8];
  logic [3:0] mosi_single   [8];

  initial begin
    reset          = 1'b1;
    bus.cs_n       = 1'b1;
    bus.mode       = 2'b00;
    bus.mosi       = 4'h0;
    bus.tx_data    = '0;
    bus.tx_valid   = 1'b0;
    bus.rx_ready   = 1'b0;
    bus.status_clr = 1'b0;
    @(negedge sclk);
    step();
    reset = 1'b0;
    step();
    check_reset_vals("reset");

    // 1: quad, TX A5
    push_tx(8'hA5);
    bus.mode = 2'b10;
    beat(4'h3);
    check("q_miso0", 32'(bus.miso), MsbFirst ? 32'hA : 32'h5);
    check("q_oe0", 32'(bus.miso_oe), 32'hF);
    beat(4'hC);
    check("q_miso1", 32'(bus.miso), MsbFirst ? 32'h5 : 32'hA);
    end_frame();
    check("q_oe_idle", 32'(bus.miso_oe), 32'h0);
    pop_rx("q_rx", MsbFirst ? 8'h3C : 8'hC3);

    // 2: single, TX 01
    push_tx(8'h01);
    bus.mode    = 2'b00;
    mosi_single = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    for (int i = 0; i < 8; i++) begin
      beat(mosi_single[i]);
      check($sformatf("s_miso%0d", i), 32'(bus.miso),
            32'((MsbFirst ? (i == 7) : (i == 0)) ? 1 : 0));
      check($sformatf("s_oe%0d", i), 32'(bus.miso_oe), 32'h1);
    end
    end_frame();
    pop_rx("s_rx", 8'h81);

    // 3: dual, two frames back-to-back
    push_tx(8'h1B);
    push_tx(8'hE4);
    bus.mode  = 2'b01;
    mosi_dual = '{4'h2, 4'h1, 4'h3, 4'h0, 4'h0, 4'h3, 4'h3, 4'h1};
    if (MsbFirst) exp_miso_dual = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h2, 4'h1, 4'h0};
    else          exp_miso_dual = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 8; i++) begin
      beat(mosi_dual[i]);
      check($sformatf("d_miso%0d", i), 32'(bus.miso), 32'(exp_miso_dual[i]));
      check($sformatf("d_oe%0d", i), 32'(bus.miso_oe), 32'h3);
    end
    end_frame();
    check("d_status", 32'(bus.status), 32'h0);
    pop_rx("d_rx0", MsbFirst ? 8'h9C : 8'h36);
    pop_rx("d_rx1", MsbFirst ? 8'h3D : 8'h7C);

    // 4: abort after one quad beat, clear coincident with the abort edge
    push_tx(8'h5A);
    bus.mode = 2'b10;
    beat(4'h7);
    check("a_miso", 32'(bus.miso), MsbFirst ? 32'h5 : 32'hA);
    bus.status_clr = 1'b1;
    end_frame();
    bus.status_clr = 1'b0;
    check("a_oe", 32'(bus.miso_oe), 32'h0);
    check("a_status", 32'(bus.status), 32'h4);
    check("a_rx_valid", 32'(bus.rx_valid), 32'd0);
    bus.status_clr = 1'b1;
    step();
    bus.status_clr = 1'b0;
    check("a_clr", 32'(bus.status), 32'h0);

    // 5: TX empty -> underrun; fill RX then overrun
    for (int f = 0; f < 5; f++) begin
      beat(4'(2 * f + 1));
      if (f == 0) check("u_miso0", 32'(bus.miso), 32'h0);
      beat(4'(2 * f + 2));
      if (f == 0) begin
        check("u_miso1", 32'(bus.miso), 32'h0);
        check("u_status", 32'(bus.status), 32'h1);
      end
    end
    end_frame();
    check("o_status", 32'(bus.status), 32'h3);
    pop_rx("o_rx0", quad_word(4'h1, 4'h2));
    pop_rx("o_rx1", quad_word(4'h3, 4'h4));
    pop_rx("o_rx2", quad_word(4'h5, 4'h6));
    pop_rx("o_rx3", quad_word(4'h7, 4'h8));
    check("o_empty", 32'(bus.rx_valid), 32'd0);
    bus.status_clr = 1'b1;
    step();
    bus.status_clr = 1'b0;

    // 6: reset mid-frame, then a clean frame
    push_tx(8'h3C);
    push_tx(8'h11);
    beat(4'h5);
    check("r_miso_pre", 32'(bus.miso), MsbFirst ? 32'h3 : 32'hC);
    reset = 1'b1;
    #1;
    check_reset_vals("r_async");
    @(negedge sclk);
    bus.cs_n = 1'b1;
    step();
    reset = 1'b0;
    step();
    push_tx(8'h96);
    beat(4'hE);
    check("r_miso0", 32'(bus.miso), MsbFirst ? 32'h9 : 32'h6);
    beat(4'hD);
    check("r_miso1", 32'(bus.miso), MsbFirst ? 32'h6 : 32'h9);
    end_frame();
    check("r_status", 32'(bus.status), 32'h0);
    pop_rx("r_rx", MsbFirst ? 8'hED : 8'hDE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
